// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding and sizing helpers for the systolic array controller.
package systolic_pkg;
    typedef enum logic [1:0] {IDLE, CLEAR, FEED, DRAIN} state_t;

    function automatic int acc_w(input int width, input int n);
        return 2 * width + $clog2(n);
    endfunction

    function automatic int drain_cyc(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(2 * n);
    endfunction
endpackage

// File: rtl/systolic_array_ctrl_if.sv
// systolic_array_ctrl_if: job handshake, operand beat stream and array edge drive.
interface systolic_array_ctrl_if #(
    parameter int WIDTH      = 8,
    parameter int ARRAY_SIZE = 4
);
    logic                        start, busy, done, in_valid, in_ready, pe_rst;
    logic [ARRAY_SIZE*WIDTH-1:0] in_a, in_b, left_out, up_out;

    modport master (
        output start, in_valid, in_a, in_b,
        input  busy, done, in_ready, left_out, up_out, pe_rst
    );

    modport slave (
        input  start, in_valid, in_a, in_b,
        output busy, done, in_ready, left_out, up_out, pe_rst
    );
endinterface

// File: rtl/skew_delay_line.sv
// skew_delay_line: DEPTH-stage shift register with synchronous clear; DEPTH 1 is a plain output register.
module skew_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sr <= '{default: '0};
        end else begin
            sr[0] <= d;
            for (int t = 1; t < DEPTH; t++) sr[t] <= sr[t-1];
        end
    end

    assign q = sr[DEPTH-1];
endmodule

// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl: job sequencer and diagonal operand skew for an N x N output-stationary systolic array.
module systolic_array_ctrl
    import systolic_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ARRAY_SIZE = 4
) (
    input logic                  clk,
    input logic                  rst,
    systolic_array_ctrl_if.slave bus
);
    localparam int N  = ARRAY_SIZE;
    localparam int CW = cnt_w(N);
    localparam logic [CW-1:0] K_LAST = CW'(N - 1);
    localparam logic [CW-1:0] D_LAST = CW'(drain_cyc(N));

    state_t            state, next;
    logic [CW-1:0]     k, dcnt;
    logic              in_ready, fire, clr;
    logic [N*WIDTH-1:0] a_d, b_d, left, up;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= next;
    end

    always_ff @(posedge clk) begin
        if (rst || state == CLEAR) k <= '0;
        else if (fire) k <= k + 1'b1;
    end

    // The last drain count doubles as the done cycle, after which all PEs hold final sums.
    always_ff @(posedge clk) begin
        if (rst || state != DRAIN) dcnt <= '0;
        else dcnt <= dcnt + 1'b1;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    next = bus.start ? CLEAR : IDLE;
            CLEAR:   next = FEED;
            FEED:    next = (fire && k == K_LAST) ? DRAIN : FEED;
            DRAIN:   next = (dcnt == D_LAST) ? IDLE : DRAIN;
            default: next = IDLE;
        endcase
    end

    // Non-handshake cycles push zero slices so the skew stays aligned and sums are unaffected.
    always_comb begin
        in_ready = state == FEED;
        fire     = bus.in_valid && in_ready;
        clr      = state == CLEAR;
        a_d      = fire ? bus.in_a : '0;
        b_d      = fire ? bus.in_b : '0;
    end

    assign bus.in_ready = in_ready;
    assign bus.busy     = state != IDLE;
    assign bus.done     = state == DRAIN && dcnt == D_LAST;
    assign bus.pe_rst   = rst || clr;
    assign bus.left_out = left;
    assign bus.up_out   = up;

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay_line #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_a (
            .clk(clk), .rst(rst), .clr(clr),
            .d(a_d[i*WIDTH +: WIDTH]), .q(left[i*WIDTH +: WIDTH])
        );
        skew_delay_line #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_b (
            .clk(clk), .rst(rst), .clr(clr),
            .d(b_d[i*WIDTH +: WIDTH]), .q(up[i*WIDTH +: WIDTH])
        );
    end
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// tb_systolic_array_ctrl: randomized jobs against a timestamp-based model of the controller and a behavioural PE array.
module tb_systolic_array_ctrl;
    import systolic_pkg::*;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int AW = acc_w(W, N);

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    systolic_array_ctrl_if #(.WIDTH(W), .ARRAY_SIZE(N)) bus ();
    systolic_array_ctrl #(.WIDTH(W), .ARRAY_SIZE(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0, n_fail = 0, n_done = 0;
    int cyc = 0, s_edge = -100, done_edge = -100, clr_edge = 0, beats = 0;
    bit active = 0;
    logic [N*W-1:0] hist_a [4096];
    logic [N*W-1:0] hist_b [4096];
    logic signed [W-1:0]  ma [N][N];
    logic signed [W-1:0]  mb [N][N];
    logic signed [AW-1:0] acc [N][N];
    logic signed [W-1:0]  ar [N][N];
    logic signed [W-1:0]  br [N][N];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Model: each edge records the slice that entered the skew lines; lane i shows the slice from i edges ago.
    always @(posedge clk) begin
        cyc++;
        hist_a[cyc % 4096] = '0;
        hist_b[cyc % 4096] = '0;
        if (rst) begin
            active = 0;
            clr_edge = cyc;
        end else if (!active) begin
            if (bus.start) begin
                active = 1;
                s_edge = cyc;
                beats = 0;
                done_edge = -100;
            end
        end else if (cyc == done_edge + 1) begin
            active = 0;
        end else if (cyc == s_edge + 1) begin
            clr_edge = cyc;
        end else if (beats < N && bus.in_valid) begin
            hist_a[cyc % 4096] = bus.in_a;
            hist_b[cyc % 4096] = bus.in_b;
            beats++;
            if (beats == N) done_edge = cyc + 2 * N - 1;
        end
    end

    // Behavioural PE array driven by the DUT edges, used to check the final dot products.
    always @(posedge clk) begin : pe_array
        logic signed [W-1:0] l, u;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) l = $signed(bus.left_out[i*W +: W]);
                else l = ar[i][j-1];
                if (i == 0) u = $signed(bus.up_out[j*W +: W]);
                else u = br[i-1][j];
                if (bus.pe_rst) begin
                    acc[i][j] <= '0;
                    ar[i][j]  <= '0;
                    br[i][j]  <= '0;
                end else begin
                    acc[i][j] <= acc[i][j] + AW'(l) * AW'(u);
                    ar[i][j]  <= l;
                    br[i][j]  <= u;
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [N*W-1:0] ea, eb;
        int idx;
        if (cyc > 0) begin
            for (int i = 0; i < N; i++) begin
                idx = cyc - i;
                ea[i*W +: W] = (idx > clr_edge) ? hist_a[idx % 4096][i*W +: W] : '0;
                eb[i*W +: W] = (idx > clr_edge) ? hist_b[idx % 4096][i*W +: W] : '0;
            end
            chk("busy", 64'(bus.busy), 64'(active));
            chk("in_ready", 64'(bus.in_ready), 64'(active && cyc >= s_edge + 1 && beats < N));
            chk("done", 64'(bus.done), 64'(active && cyc == done_edge));
            chk("pe_rst", 64'(bus.pe_rst), 64'(rst || (active && cyc == s_edge)));
            chk("left_out", 64'(bus.left_out), 64'(ea));
            chk("up_out", 64'(bus.up_out), 64'(eb));
            if (bus.done) n_done++;
        end
    end

    task automatic job(input int gaps, input bit noisy, input int abort);
        int s, b, g, nd0, d, cref;
        bit v, f;
        nd0 = n_done;
        bus.start = 1;
        step;
        bus.start = 0;
        s = cyc;
        b = 0;
        g = gaps;
        for (int t = 0; t < 100 && b < N; t++) begin
            v = !(bus.in_ready && g > 0 && (b == N - 1 || $urandom_range(0, 1) == 1));
            f = v && bus.in_ready;
            if (bus.in_ready && !v) g--;
            bus.in_valid = v;
            for (int i = 0; i < N; i++) begin
                bus.in_a[i*W +: W] = ma[i][b];
                bus.in_b[i*W +: W] = mb[b][i];
            end
            bus.start = noisy && bus.in_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            step;
            if (f) b++;
        end
        chk("all_beats_fed", 64'(b), 64'(N));
        bus.in_valid = 0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.start = 0;
        if (abort > 0) begin
            repeat (abort) step;
            rst = 1;
            step;
            rst = 0;
            chk("abort_busy", 64'(bus.busy), 64'(0));
            repeat (3 * N) step;
            chk("abort_no_done", 64'(n_done - nd0), 64'(0));
            return;
        end
        for (d = 0; d < 4 * N && bus.done !== 1'b1; d++) step;
        chk("done_seen", 64'(bus.done), 64'(1));
        chk("latency", 64'(cyc - s), 64'(3 * N + gaps));
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                cref = 0;
                for (int k = 0; k < N; k++) cref += int'(ma[i][k]) * int'(mb[k][j]);
                chk($sformatf("sum[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(cref));
            end
        end
        bus.start = 1;
        step;
        bus.start = 0;
        chk("start_on_done_ignored", 64'(bus.busy), 64'(0));
        repeat (2) step;
        chk("one_done", 64'(n_done - nd0), 64'(1));
    endtask

    task automatic skew_test;
        int e;
        bus.start = 1;
        step;
        bus.start = 0;
        step;
        bus.in_valid = 1;
        bus.in_a = {N{8'h01}};
        bus.in_b = {N{8'h01}};
        step;
        e = cyc;
        bus.in_valid = 0;
        bus.in_a = '0;
        bus.in_b = '0;
        for (int t = 0; t <= N; t++) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("skew_left[%0d]@e+%0d", i, t), 64'(bus.left_out[i*W +: W]), 64'(t == i ? 1 : 0));
                chk($sformatf("skew_up[%0d]@e+%0d", i, t), 64'(bus.up_out[i*W +: W]), 64'(t == i ? 1 : 0));
            end
            step;
        end
        chk("skew_edge", 64'(cyc - e), 64'(N + 1));
        bus.in_valid = 1;
        repeat (N - 1) step;
        bus.in_valid = 0;
        for (int d = 0; d < 4 * N && bus.done !== 1'b1; d++) step;
        chk("skew_done", 64'(bus.done), 64'(1));
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("skew_sum[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(1));
        repeat (2) step;
    endtask

    initial begin
        bus.start = 0;
        bus.in_valid = 0;
        bus.in_a = '0;
        bus.in_b = '0;
        repeat (3) step;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_left", 64'(bus.left_out), 64'(0));
        chk("rst_up", 64'(bus.up_out), 64'(0));
        chk("rst_pe_rst", 64'(bus.pe_rst), 64'(1));
        rst = 0;
        step;

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = W'(i == j ? 1 : 0);
                mb[i][j] = W'(i == j ? 1 : 0);
            end
        job(0, 0, 0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("identity[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(i == j ? 1 : 0));

        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                ma[i][k] = W'(i + k + 1);
                mb[i][k] = W'(k - i);
            end
        job(2, 1, 0);
        chk("ramp_sum00", 64'(acc[0][0]), 64'(-20));

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = -8'sd128;
                mb[i][j] = -8'sd128;
            end
        job($urandom_range(0, 3), 0, 0);
        chk("neg_extreme00", 64'(acc[0][0]), 64'(65536));
        chk("neg_extreme33", 64'(acc[N-1][N-1]), 64'(65536));

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = $urandom_range(0, 1) ? -8'sd128 : 8'sd127;
                mb[i][j] = $urandom_range(0, 1) ? -8'sd128 : 8'sd127;
            end
        job(1, 0, 0);

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = W'($urandom);
                mb[i][j] = W'($urandom);
            end
        job(0, 0, 3);
        job(1, 0, 0);

        skew_test();

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    ma[i][j] = W'($urandom);
                    mb[i][j] = W'($urandom);
                end
            job($urandom_range(0, 4), 1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
